// File: rtl/fetch_sequencer_if.sv
// Fetch-stage bus between the PC register / decode / execute and the fetch sequencer.
// master drives the fetch inputs and receives next-PC; slave is the sequencer itself.
interface fetch_sequencer_if #(
  parameter int unsigned PC_W    = 13,
  parameter int unsigned INSTR_W = 16,
  parameter int unsigned CNT_W   = 16
);
  logic [PC_W-1:0]    pc;
  logic [PC_W-1:0]    pc_plus1;
  logic [INSTR_W-1:0] instr;
  logic               stall;
  logic               branch_taken;
  logic [PC_W-1:0]    branch_target;
  logic               resume;
  logic [PC_W-1:0]    new_pc;
  logic               instr_valid;
  logic               flush;
  logic               halted;
  logic [CNT_W-1:0]   fetch_count;

  modport master (
    output pc, pc_plus1, instr, stall, branch_taken, branch_target, resume,
    input  new_pc, instr_valid, flush, halted, fetch_count
  );

  modport slave (
    input  pc, pc_plus1, instr, stall, branch_taken, branch_target, resume,
    output new_pc, instr_valid, flush, halted, fetch_count
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Next-PC sequencer for the fetch stage: boot, run, stall-hold and halt states,
// branch redirect with wrong-path flush, and a saturating valid-fetch counter.
module fetch_sequencer #(
  parameter int unsigned     PC_W     = 13,
  parameter int unsigned     INSTR_W  = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter logic [4:0]      HALT_OP  = 5'b00000,
  parameter int unsigned     CNT_W    = 16
) (
  input  logic               clk,
  input  logic               rst,
  fetch_sequencer_if.slave   bus
);

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    STALL  = 2'd2,
    HALTED = 2'd3
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic               halted_q;
  logic [CNT_W-1:0]   count_q;
  logic [PC_W-1:0]    new_pc_c;
  logic               valid_c;
  logic               flush_c;
  logic               is_halt_op;
  logic               unused_instr_bits;

  // Opcode lives in the top five instruction bits; the rest is decode's business.
  assign is_halt_op        = (bus.instr[INSTR_W-1 -: 5] == HALT_OP);
  assign unused_instr_bits = ^bus.instr[INSTR_W-6:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= BOOT;
      halted_q <= 1'b0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      halted_q <= (state_d == HALTED);
      if (valid_c && (count_q != '1)) begin
        count_q <= count_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    new_pc_c = RESET_PC;
    valid_c  = 1'b0;
    flush_c  = 1'b0;
    if (rst) begin
      state_d = BOOT;
    end else begin
      unique case (state_q)
        BOOT: begin
          state_d = RUN;
        end
        RUN, STALL: begin
          // Redirect beats the halt opcode, which beats stall.
          if (bus.branch_taken) begin
            new_pc_c = bus.branch_target;
            flush_c  = 1'b1;
            state_d  = RUN;
          end else if (is_halt_op) begin
            new_pc_c = bus.pc;
            valid_c  = 1'b1;
            state_d  = HALTED;
          end else if (bus.stall) begin
            new_pc_c = bus.pc;
            state_d  = STALL;
          end else begin
            new_pc_c = bus.pc_plus1;
            valid_c  = 1'b1;
            state_d  = RUN;
          end
        end
        HALTED: begin
          if (bus.resume) begin
            new_pc_c = bus.pc_plus1;
            state_d  = RUN;
          end else begin
            new_pc_c = bus.pc;
          end
        end
        default: begin
          state_d = BOOT;
        end
      endcase
    end
  end

  assign bus.new_pc      = new_pc_c;
  assign bus.instr_valid = valid_c;
  assign bus.flush       = flush_c;
  assign bus.halted      = halted_q;
  assign bus.fetch_count = count_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed-vector bench for fetch_sequencer: stimulus pushes hand-computed expectations
// into a queue and a negedge monitor pops and compares them against the DUT outputs.
module tb_fetch_sequencer;

  localparam logic [15:0] NOP = 16'h0800;
  localparam logic [15:0] HLT = 16'h0000;

  typedef struct {
    logic [12:0] npc;
    logic        v;
    logic        f;
    logic        h;
    logic [15:0] cnt;
  } exp_t;

  logic clk;
  logic rst;
  exp_t q[$];
  int   total;
  int   bad;

  fetch_sequencer_if #(.PC_W(13), .INSTR_W(16), .CNT_W(16)) bus ();

  fetch_sequencer #(
    .PC_W(13), .INSTR_W(16), .RESET_PC(13'h0000), .HALT_OP(5'b00000), .CNT_W(16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, want, $time);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("new_pc",      32'(bus.new_pc),      32'(e.npc));
      chk("instr_valid", 32'(bus.instr_valid), 32'(e.v));
      chk("flush",       32'(bus.flush),       32'(e.f));
      chk("halted",      32'(bus.halted),      32'(e.h));
      chk("fetch_count", 32'(bus.fetch_count), 32'(e.cnt));
    end
  end

  task automatic step(
    input logic r, input logic [12:0] p, input logic [12:0] p1, input logic [15:0] in,
    input logic st, input logic br, input logic [12:0] tgt, input logic rs,
    input logic [12:0] enpc, input logic ev, input logic ef, input logic eh,
    input logic [15:0] ecnt);
    exp_t e;
    @(posedge clk);
    #1;
    rst               = r;
    bus.pc            = p;
    bus.pc_plus1      = p1;
    bus.instr         = in;
    bus.stall         = st;
    bus.branch_taken  = br;
    bus.branch_target = tgt;
    bus.resume        = rs;
    e.npc = enpc; e.v = ev; e.f = ef; e.h = eh; e.cnt = ecnt;
    q.push_back(e);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus.pc = '0; bus.pc_plus1 = '0; bus.instr = NOP; bus.stall = 1'b0;
    bus.branch_taken = 1'b0; bus.branch_target = '0; bus.resume = 1'b0;
    @(posedge clk);

    //     rst  pc       pc+1     instr st   br   tgt      rs   new_pc   v    f    h    cnt
    step(1'b1, 13'h000, 13'h001, NOP, 1'b0, 1'b0, 13'h000, 1'b0, 13'h000, 1'b0, 1'b0, 1'b0, 16'd0);
    step(1'b0, 13'h000, 13'h001, NOP, 1'b0, 1'b0, 13'h000, 1'b0, 13'h000, 1'b0, 1'b0, 1'b0, 16'd0);
    step(1'b0, 13'h000, 13'h001, NOP, 1'b0, 1'b0, 13'h000, 1'b0, 13'h001, 1'b1, 1'b0, 1'b0, 16'd0);
    step(1'b0, 13'h001, 13'h002, NOP, 1'b0, 1'b0, 13'h000, 1'b0, 13'h002, 1'b1, 1'b0, 1'b0, 16'd1);
    step(1'b0, 13'h002, 13'h003, NOP, 1'b0, 1'b0, 13'h000, 1'b0, 13'h003, 1'b1, 1'b0, 1'b0, 16'd2);
    step(1'b0, 13'h003, 13'h004, NOP, 1'b0, 1'b0, 13'h000, 1'b0, 13'h004, 1'b1, 1'b0, 1'b0, 16'd3);
    step(1'b0, 13'h004, 13'h005, NOP, 1'b0, 1'b0, 13'h000, 1'b0, 13'h005, 1'b1, 1'b0, 1'b0, 16'd4);
    // stall holds pc=5 for two cycles
    step(1'b0, 13'h005, 13'h006, NOP, 1'b1, 1'b0, 13'h000, 1'b0, 13'h005, 1'b0, 1'b0, 1'b0, 16'd5);
    step(1'b0, 13'h005, 13'h006, NOP, 1'b1, 1'b0, 13'h000, 1'b0, 13'h005, 1'b0, 1'b0, 1'b0, 16'd5);
    step(1'b0, 13'h005, 13'h006, NOP, 1'b0, 1'b0, 13'h000, 1'b0, 13'h006, 1'b1, 1'b0, 1'b0, 16'd5);
    step(1'b0, 13'h006, 13'h007, NOP, 1'b0, 1'b0, 13'h000, 1'b0, 13'h007, 1'b1, 1'b0, 1'b0, 16'd6);
    // branch with stall and halt opcode present: redirect wins
    step(1'b0, 13'h007, 13'h008, HLT, 1'b1, 1'b1, 13'h100, 1'b0, 13'h100, 1'b0, 1'b1, 1'b0, 16'd7);
    step(1'b0, 13'h100, 13'h101, NOP, 1'b0, 1'b0, 13'h000, 1'b0, 13'h101, 1'b1, 1'b0, 1'b0, 16'd7);
    step(1'b0, 13'h101, 13'h102, NOP, 1'b0, 1'b1, 13'h020, 1'b0, 13'h020, 1'b0, 1'b1, 1'b0, 16'd8);
    // halt at 0x20
    step(1'b0, 13'h020, 13'h021, HLT, 1'b0, 1'b0, 13'h000, 1'b0, 13'h020, 1'b1, 1'b0, 1'b0, 16'd8);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 13'h020, 13'h021, NOP, 1'((i % 2) == 1), 1'(((i / 2) % 2) == 1), 13'h300, 1'b0,
           13'h020, 1'b0, 1'b0, 1'b1, 16'd9);
    end
    step(1'b0, 13'h020, 13'h021, NOP, 1'b0, 1'b1, 13'h300, 1'b1, 13'h021, 1'b0, 1'b0, 1'b1, 16'd9);
    step(1'b0, 13'h021, 13'h022, NOP, 1'b0, 1'b0, 13'h000, 1'b0, 13'h022, 1'b1, 1'b0, 1'b0, 16'd9);
    step(1'b0, 13'h022, 13'h023, NOP, 1'b0, 1'b0, 13'h000, 1'b0, 13'h023, 1'b1, 1'b0, 1'b0, 16'd10);
    // pc_plus1 wrap passes straight through
    step(1'b0, 13'h1FFF, 13'h000, NOP, 1'b0, 1'b0, 13'h000, 1'b0, 13'h000, 1'b1, 1'b0, 1'b0, 16'd11);
    step(1'b0, 13'h000, 13'h001, NOP, 1'b0, 1'b0, 13'h000, 1'b0, 13'h001, 1'b1, 1'b0, 1'b0, 16'd12);
    // reset during STALL
    step(1'b0, 13'h001, 13'h002, NOP, 1'b1, 1'b0, 13'h000, 1'b0, 13'h001, 1'b0, 1'b0, 1'b0, 16'd13);
    step(1'b0, 13'h001, 13'h002, NOP, 1'b1, 1'b0, 13'h000, 1'b0, 13'h001, 1'b0, 1'b0, 1'b0, 16'd13);
    step(1'b1, 13'h001, 13'h002, NOP, 1'b1, 1'b1, 13'h055, 1'b0, 13'h000, 1'b0, 1'b0, 1'b0, 16'd13);
    step(1'b0, 13'h001, 13'h002, NOP, 1'b1, 1'b1, 13'h055, 1'b0, 13'h000, 1'b0, 1'b0, 1'b0, 16'd0);
    step(1'b0, 13'h000, 13'h001, NOP, 1'b0, 1'b0, 13'h000, 1'b0, 13'h001, 1'b1, 1'b0, 1'b0, 16'd0);
    // reset during HALTED
    step(1'b0, 13'h001, 13'h002, HLT, 1'b0, 1'b0, 13'h000, 1'b0, 13'h001, 1'b1, 1'b0, 1'b0, 16'd1);
    step(1'b0, 13'h001, 13'h002, NOP, 1'b0, 1'b0, 13'h000, 1'b0, 13'h001, 1'b0, 1'b0, 1'b1, 16'd2);
    step(1'b1, 13'h001, 13'h002, NOP, 1'b0, 1'b0, 13'h000, 1'b1, 13'h000, 1'b0, 1'b0, 1'b1, 16'd2);
    step(1'b0, 13'h001, 13'h002, NOP, 1'b0, 1'b0, 13'h000, 1'b0, 13'h000, 1'b0, 1'b0, 1'b0, 16'd0);
    // long valid run to drive the counter into saturation
    for (int i = 0; i < 65540; i++) begin
      step(1'b0, 13'h000, 13'h001, NOP, 1'b0, 1'b0, 13'h000, 1'b0, 13'h001, 1'b1, 1'b0, 1'b0,
           (i < 65535) ? 16'(i) : 16'hFFFF);
    end

    repeat (3) @(negedge clk);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
